// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// Follows Tx_BUSY to find frame start and end, and flags writes the transmitter never picks up.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic [7:0]                 Tx_DATA,
  output logic                       Tx_WR,
  output logic                       Tx_EN,
  input  logic                       Tx_BUSY
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(START_TIMEOUT + 1);

  localparam logic [IDW-1:0]     LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]      CNT_LIMIT = CW'(START_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [IDW-1:0]     lastId_q;
  logic [IDW-1:0]     activeId_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               err_q;
  logic               busy_q;
  logic [7:0]         txData_q;
  logic               txWr_q;
  logic               txEn_q;

  logic               selValid_d;
  logic [IDW-1:0]     selId_d;
  logic [7:0]         selData_d;
  logic [IDW-1:0]     searchIdx;
  logic [7:0]         reqByte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign reqByte[g] = req_data[8*g +: 8];
  end

  // Rotating-priority search: start just after the last served requester and wrap.
  always_comb begin
    searchIdx  = lastId_q;
    selValid_d = 1'b0;
    selId_d    = lastId_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      searchIdx = (searchIdx == LAST_ID) ? '0 : searchIdx + 1'b1;
      if (!selValid_d && req[searchIdx]) begin
        selValid_d = 1'b1;
        selId_d    = searchIdx;
      end
    end
    selData_d = reqByte[selId_d];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lastId_q   <= LAST_ID;
      activeId_q <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      txData_q   <= 8'h00;
      txWr_q     <= 1'b0;
      txEn_q     <= 1'b0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (selValid_d) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            lastId_q   <= selId_d;
            activeId_q <= selId_d;
            grant_q    <= ONE_HOT0 << selId_d;
            txData_q   <= selData_d;
            txWr_q     <= 1'b1;
            txEn_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_START: begin
          if (Tx_BUSY) begin
            state_q <= S_SEND;
            txWr_q  <= 1'b0;
          end else if (cnt_q == CNT_LIMIT) begin
            // Transmitter never acknowledged the write: abandon it without a done pulse.
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b1;
            txWr_q  <= 1'b0;
            txEn_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SEND: begin
          if (!Tx_BUSY) begin
            state_q <= S_DONE;
            done_q  <= ONE_HOT0 << activeId_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          txEn_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          txWr_q  <= 1'b0;
          txEn_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign active_id = activeId_q;
  assign busy      = busy_q;
  assign Tx_DATA   = txData_q;
  assign Tx_WR     = txWr_q;
  assign Tx_EN     = txEn_q;

endmodule
